// File: rtl/ram_bist.sv
// SRAM built-in self-test: writes a pattern over 0..LAST_ADR, reads it back and compares.
// Two cycles per access with a zero-wait slave; one access outstanding, held while stall_i is high.
module ram_bist #(
  parameter int          AW       = 19,
  parameter int          DW       = 16,
  parameter int          LAST_ADR = 2**AW - 1,
  parameter int          ECW      = 16,
  parameter logic [31:0] SEED     = 32'h0000_0001
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  output logic              cyc_o,
  output logic              stb_o,
  output logic              we_o,
  output logic [DW/8-1:0]   sel_o,
  output logic [AW-1:0]     adr_o,
  output logic [DW-1:0]     dat_o,
  input  logic              ack_i,
  input  logic              stall_i,
  input  logic [DW-1:0]     dat_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [ECW-1:0]    err_count_o,
  output logic [AW-1:0]     first_err_adr_o
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t         state, state_nxt;
  logic [1:0]     mode_q;
  logic [AW-1:0]  adr_q;
  logic [31:0]    lfsr_q;
  logic [31:0]    lfsr_nxt;
  logic           stb_q, pend_q, cyc_q, busy_q, done_q, pass_q;
  logic [ECW-1:0] err_q;
  logic [AW-1:0]  first_q;
  logic [DW-1:0]  pat;
  logic           start_ok, accept, ack_ok, last, miss;

  assign start_ok = ((state == IDLE) || (state == DONE)) && start_i;
  assign accept   = stb_q & ~stall_i;
  // Acks are only meaningful while an accepted access is waiting for them.
  assign ack_ok   = pend_q & ack_i;
  assign last     = (adr_q == AW'(LAST_ADR));
  assign miss     = (dat_i != pat);

  always_comb begin
    lfsr_nxt = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
    unique case (mode_q)
      2'd0:    pat = DW'(adr_q);
      2'd1:    pat = ~DW'(adr_q);
      2'd2:    pat = lfsr_q[DW-1:0];
      default: pat = {{(DW-1){1'b0}}, 1'b1} << (int'(adr_q) % DW);
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start_i) state_nxt = WRITE;
      WRITE:      if (ack_ok && last) state_nxt = READ;
      default:    if (ack_ok && last) state_nxt = DONE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      mode_q  <= 2'd0;
      adr_q   <= '0;
      lfsr_q  <= '0;
      stb_q   <= 1'b0;
      pend_q  <= 1'b0;
      cyc_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      first_q <= '0;
    end else if (start_ok) begin
      mode_q  <= mode_i;
      adr_q   <= '0;
      lfsr_q  <= SEED;
      stb_q   <= 1'b1;
      pend_q  <= 1'b0;
      cyc_q   <= 1'b1;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      first_q <= '0;
    end else begin
      if (accept) begin
        stb_q  <= 1'b0;
        pend_q <= 1'b1;
      end
      if (ack_ok) begin
        pend_q <= 1'b0;
        if ((state == READ) && miss) begin
          if (err_q != {ECW{1'b1}}) err_q <= err_q + 1'b1;
          if (err_q == '0) first_q <= adr_q;
        end
        if (!last) begin
          adr_q  <= adr_q + 1'b1;
          lfsr_q <= lfsr_nxt;
          stb_q  <= 1'b1;
        end else if (state == WRITE) begin
          adr_q  <= '0;
          lfsr_q <= SEED;
          stb_q  <= 1'b1;
        end else begin
          cyc_q  <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          pass_q <= (err_q == '0) && !miss;
        end
      end
    end
  end

  assign cyc_o           = cyc_q;
  assign stb_o           = stb_q;
  assign we_o            = cyc_q && (state == WRITE);
  assign sel_o           = '1;
  assign adr_o           = cyc_q ? adr_q : '0;
  assign dat_o           = (state == WRITE) ? pat : '0;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign pass_o          = pass_q;
  assign err_count_o     = err_q;
  assign first_err_adr_o = first_q;

endmodule

// File: tb/tb_ram_bist.sv
// Directed bench for ram_bist: 32-word SRAM slave model with stall/ack-delay and fault injection.
`timescale 1ns/1ps
module tb_ram_bist;
  localparam int AW = 5;
  localparam int DW = 16;
  localparam int LAST = 31;
  localparam int ECW = 4;

  logic           clk;
  logic           reset_i, start_i;
  logic [1:0]     mode_i;
  logic           cyc_o, stb_o, we_o;
  logic [1:0]     sel_o;
  logic [AW-1:0]  adr_o;
  logic [DW-1:0]  dat_o;
  logic           ack_i, stall_i;
  logic [DW-1:0]  dat_i;
  logic           busy_o, done_o, pass_o;
  logic [ECW-1:0] err_count_o;
  logic [AW-1:0]  first_err_adr_o;

  int total, bad;

  // slave model state
  int         stall_cfg, ack_dly, stall_left, ack_cnt;
  int         wr_seen, rd_seen, seq_bad, dat_bad;
  bit         stuck, zero_rd;
  logic [1:0] cur_mode;
  logic [15:0] mem    [32];
  logic [15:0] wr_log [32];
  logic [15:0] rd_val;

  ram_bist #(.AW(AW), .DW(DW), .LAST_ADR(LAST), .ECW(ECW), .SEED(32'h0000_0001)) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .mode_i(mode_i),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o), .adr_o(adr_o), .dat_o(dat_o),
    .ack_i(ack_i), .stall_i(stall_i), .dat_i(dat_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .err_count_o(err_count_o), .first_err_adr_o(first_err_adr_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] exp_pat(input logic [1:0] m, input logic [4:0] a);
    logic [15:0] one;
    one = 16'h0001;
    case (m)
      2'd0:    return {11'b0, a};
      2'd1:    return ~{11'b0, a};
      default: return one << a[3:0];
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_model(input int st, input int dly, input bit stk, input bit zr);
    stall_cfg = st; stall_left = st; ack_dly = dly; stuck = stk; zero_rd = zr;
    ack_cnt = 0; wr_seen = 0; rd_seen = 0; seq_bad = 0; dat_bad = 0;
  endtask

  task automatic start_test(input logic [1:0] m);
    cur_mode = m;
    mode_i   = m;
    @(negedge clk) start_i = 1'b1;
    @(negedge clk) start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int cyc);
    int n;
    cyc = 0;
    n = 0;
    while (!done_o && n < 3000) begin
      if (busy_o) cyc++;
      n++;
      @(negedge clk);
    end
    chk({tag, "_done"}, 32'(done_o), 32'd1);
  endtask

  task automatic run_check(input string tag, input bit exp_pass, input int exp_err, input int exp_first);
    chk({tag, "_pass"},  32'(pass_o), 32'(exp_pass));
    chk({tag, "_err"},   32'(err_count_o), 32'(exp_err));
    chk({tag, "_first"}, 32'(first_err_adr_o), 32'(exp_first));
    chk({tag, "_busy"},  32'(busy_o), 32'd0);
    chk({tag, "_cyc"},   32'(cyc_o), 32'd0);
    chk({tag, "_nwr"},   32'(wr_seen), 32'd32);
    chk({tag, "_nrd"},   32'(rd_seen), 32'd32);
    chk({tag, "_seq"},   32'(seq_bad), 32'd0);
    chk({tag, "_wdat"},  32'(dat_bad), 32'd0);
  endtask

  // Wishbone pipelined slave: acts on negedges, sees what the DUT will present at the next posedge.
  initial begin : slave
    int a;
    stall_i = 1'b0; ack_i = 1'b0; dat_i = '0; rd_val = '0;
    forever begin
      @(negedge clk);
      ack_i   = 1'b0;
      stall_i = 1'b0;
      if (ack_cnt > 0) begin
        if (stb_o) seq_bad++;
        ack_cnt--;
        if (ack_cnt == 0) begin
          ack_i = 1'b1;
          dat_i = rd_val;
        end
      end else if (stb_o && reset_i) begin
        if (stall_left > 0) begin
          stall_i = 1'b1;
          stall_left--;
        end else begin
          stall_left = stall_cfg;
          ack_cnt    = 1 + ack_dly;
          a          = int'(adr_o);
          if (!cyc_o) seq_bad++;
          if (we_o) begin
            if (a != wr_seen) seq_bad++;
            mem[a]    = dat_o;
            wr_log[a] = dat_o;
            if (cur_mode != 2'd2 && dat_o !== exp_pat(cur_mode, adr_o)) dat_bad++;
            wr_seen++;
          end else begin
            if (a != rd_seen || wr_seen != 32) seq_bad++;
            rd_val = zero_rd ? 16'h0000 : mem[a];
            if (stuck && a == 5) rd_val[3] = 1'b1;
            rd_seen++;
          end
        end
      end
    end
  end

  initial begin : main
    int cyc;
    int n;
    bit hit;
    total = 0; bad = 0;
    reset_i = 1'b0; start_i = 1'b0; mode_i = 2'd0; cur_mode = 2'd0;
    cfg_model(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_cyc",   32'(cyc_o), 32'd0);
    chk("rst_stb",   32'(stb_o), 32'd0);
    chk("rst_we",    32'(we_o), 32'd0);
    chk("rst_adr",   32'(adr_o), 32'd0);
    chk("rst_dat",   32'(dat_o), 32'd0);
    chk("rst_busy",  32'(busy_o), 32'd0);
    chk("rst_done",  32'(done_o), 32'd0);
    chk("rst_pass",  32'(pass_o), 32'd0);
    chk("rst_err",   32'(err_count_o), 32'd0);
    chk("rst_first", 32'(first_err_adr_o), 32'd0);
    chk("sel_ones",  32'(sel_o), 32'd3);
    reset_i = 1'b1;
    @(negedge clk);

    // zero-wait slave, counter pattern: 64 accesses x 2 cycles
    cfg_model(0, 0, 0, 0);
    start_test(2'd0);
    wait_done("m0", cyc);
    chk("m0_cycles", 32'(cyc), 32'd128);
    run_check("m0", 1'b1, 0, 0);
    chk("m0_w9", 32'(wr_log[9]), 32'h0009);

    // 3 stall cycles per strobe, ack 2 cycles late: 7 cycles per access
    cfg_model(3, 2, 0, 0);
    start_test(2'd0);
    wait_done("stall", cyc);
    chk("stall_cycles", 32'(cyc), 32'd448);
    run_check("stall", 1'b1, 0, 0);

    // bit 3 stuck high at address 5: reads back 0x000D
    cfg_model(0, 0, 1, 0);
    start_test(2'd0);
    wait_done("stuck", cyc);
    run_check("stuck", 1'b0, 1, 5);

    // walking one
    cfg_model(0, 0, 0, 0);
    start_test(2'd3);
    wait_done("walk", cyc);
    chk("walk_w0",  32'(wr_log[0]),  32'h0001);
    chk("walk_w15", 32'(wr_log[15]), 32'h8000);
    chk("walk_w16", 32'(wr_log[16]), 32'h0001);
    chk("walk_w17", 32'(wr_log[17]), 32'h0002);
    run_check("walk", 1'b1, 0, 0);

    // LFSR from seed 1: 1, 3, 6, D, 1B
    cfg_model(0, 0, 0, 0);
    start_test(2'd2);
    wait_done("lfsr", cyc);
    chk("lfsr_w0", 32'(wr_log[0]), 32'h0001);
    chk("lfsr_w1", 32'(wr_log[1]), 32'h0003);
    chk("lfsr_w2", 32'(wr_log[2]), 32'h0006);
    chk("lfsr_w3", 32'(wr_log[3]), 32'h000D);
    chk("lfsr_w4", 32'(wr_log[4]), 32'h001B);
    run_check("lfsr", 1'b1, 0, 0);

    // every read returns 0 against the inverted pattern: counter saturates at 15
    cfg_model(0, 0, 0, 1);
    start_test(2'd1);
    wait_done("sat", cyc);
    run_check("sat", 1'b0, 15, 0);

    // reset while the write strobe for address 7 is up
    cfg_model(0, 0, 0, 0);
    start_test(2'd0);
    hit = 1'b0;
    n = 0;
    while (!hit && n < 200) begin
      if (stb_o && we_o && adr_o == 5'd7) hit = 1'b1;
      else begin
        n++;
        @(negedge clk);
      end
    end
    chk("rstmid_found", 32'(hit), 32'd1);
    reset_i = 1'b0;
    @(negedge clk);
    chk("rstmid_cyc",  32'(cyc_o), 32'd0);
    chk("rstmid_stb",  32'(stb_o), 32'd0);
    chk("rstmid_busy", 32'(busy_o), 32'd0);
    chk("rstmid_done", 32'(done_o), 32'd0);
    chk("rstmid_adr",  32'(adr_o), 32'd0);
    reset_i = 1'b1;
    hit = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (cyc_o || stb_o || busy_o) hit = 1'b1;
    end
    chk("rstmid_quiet", 32'(hit), 32'd0);

    // start pulse (with a different mode) during READ must be ignored
    cfg_model(0, 0, 0, 0);
    start_test(2'd0);
    n = 0;
    while (!(cyc_o && !we_o) && n < 500) begin
      n++;
      @(negedge clk);
    end
    chk("ign_inread", 32'(cyc_o && !we_o), 32'd1);
    mode_i  = 2'd1;
    start_i = 1'b1;
    @(negedge clk) start_i = 1'b0;
    wait_done("ign", cyc);
    run_check("ign", 1'b1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
